// File: rtl/id_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Each access is grant (IDLE) -> memory access (ACCESS) -> registered response.
module id_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_SIZE  = 4,
  parameter int MEM_BYTES  = 84
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_req,
  input  logic [ADDR_WIDTH-1:0]  if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic                   if_err,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [ADDR_WIDTH-1:0]  d_addr,
  input  logic [BYTE_SIZE*8-1:0] d_wdata,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic                   d_err,
  output logic [BYTE_SIZE*8-1:0] rdata,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [BYTE_SIZE*8-1:0] mem_wd,
  input  logic [BYTE_SIZE*8-1:0] mem_rd
);

  localparam int DW = BYTE_SIZE * 8;
  // Highest legal start address; compared at full address width so large addresses never wrap.
  localparam logic [ADDR_WIDTH-1:0] LAST_OK = ADDR_WIDTH'(MEM_BYTES - BYTE_SIZE);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {PORT_DATA, PORT_FETCH} port_t;

  state_t                state, state_nxt;
  port_t                 prio, owner;
  logic                  grant_if, grant_d;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [DW-1:0]         req_wd;
  logic                  oob;
  logic [ADDR_WIDTH-1:0] sel_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // rst_n gates the grant so nothing is accepted while reset is held.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (if_req && (!d_req || prio == PORT_FETCH)) grant_if = 1'b1;
          else if (d_req)                               grant_d  = 1'b1;
          if (grant_if || grant_d) state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign if_gnt   = grant_if;
  assign d_gnt    = grant_d;
  assign sel_addr = grant_if ? if_addr : d_addr;
  assign mem_addr = req_addr;
  assign mem_wd   = req_wd;
  assign mem_we   = (state == ACCESS) && req_we && !oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= PORT_DATA;
      owner     <= PORT_DATA;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wd    <= '0;
      oob       <= 1'b0;
      rdata     <= '0;
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      if (grant_if || grant_d) begin
        req_addr <= sel_addr;
        req_we   <= grant_d && d_we;
        req_wd   <= grant_d ? d_wdata : '0;
        oob      <= sel_addr > LAST_OK;
        owner    <= grant_if ? PORT_FETCH : PORT_DATA;
        prio     <= grant_if ? PORT_DATA : PORT_FETCH;
      end
      if (state == ACCESS) begin
        rdata <= oob ? '0 : mem_rd;
        if (owner == PORT_FETCH) begin
          if_rvalid <= 1'b1;
          if_err    <= oob;
        end else begin
          d_rvalid  <= 1'b1;
          d_err     <= oob;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_mem_arbiter.sv
// Directed and randomized checks of id_mem_arbiter against a transaction-level
// arbitration model and a reference byte memory kept in the bench.
module tb_id_mem_arbiter;
  localparam int AW = 32, BS = 4, MB = 84, DW = 32, LIMIT = MB - BS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          if_req, if_gnt, if_rvalid, if_err;
  logic [AW-1:0] if_addr;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, rdata, mem_wd, mem_rd;
  logic          mem_we;
  logic [AW-1:0] mem_addr;

  id_mem_arbiter #(.ADDR_WIDTH(AW), .BYTE_SIZE(BS), .MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_err(d_err), .rdata(rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Backing memory seen by the DUT; loaded through ld_* during reset.
  logic [7:0]  mem [MB];
  logic        ld_en = 1'b0;
  int          ld_a = 0;
  logic [7:0]  ld_d = '0;
  logic        bad_wr = 1'b0;

  always_comb begin
    mem_rd = 32'hA5A5A5A5;
    if (mem_addr <= AW'(LIMIT))
      for (int b = 0; b < BS; b++) mem_rd[b*8 +: 8] = mem[int'(mem_addr) + b];
  end

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    if (mem_we) begin
      if (mem_addr <= AW'(LIMIT))
        for (int b = 0; b < BS; b++) mem[int'(mem_addr) + b] <= mem_wd[b*8 +: 8];
      else
        bad_wr <= 1'b1;
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [MB];
  int          n_cmp = 0, n_err = 0, cyc = 0;
  int          m_free, m_prio;          // m_prio: 0 = data, 1 = fetch
  int          acc_at, resp_at, resp_port;
  logic [31:0] acc_addr, acc_wd, resp_data, last_rdata;
  bit          acc_we, resp_err, m_gi, m_gd;
  // Values sampled from the DUT in the last tick
  logic        s_if_gnt, s_d_gnt, s_if_rv, s_d_rv, s_if_err, s_d_err, s_mem_we;
  logic [31:0] s_rdata, s_mem_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input longint a);
    logic [31:0] w;
    for (int b = 0; b < BS; b++) w[b*8 +: 8] = ref_mem[int'(a) + b];
    return w;
  endfunction

  task automatic model_reset();
    m_prio = 0; m_free = cyc; acc_at = -1; resp_at = -1; last_rdata = '0;
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+4, advance to next posedge+1.
  task automatic tick(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                      input logic [31:0] da, input logic [31:0] dwd);
    int win;
    longint a;
    bit oob;
    if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    #3;
    s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_if_rv = if_rvalid; s_d_rv = d_rvalid;
    s_if_err = if_err; s_d_err = d_err; s_rdata = rdata; s_mem_addr = mem_addr; s_mem_we = mem_we;

    chk("mem_we", mem_we, (cyc == acc_at) && acc_we);
    if (cyc == acc_at) begin
      chk("mem_addr", mem_addr, acc_addr);
      if (acc_we) begin
        chk("mem_wd", mem_wd, acc_wd);
        for (int b = 0; b < BS; b++) ref_mem[int'(acc_addr) + b] = acc_wd[b*8 +: 8];
      end
    end
    if (cyc == resp_at) last_rdata = resp_data;
    chk("if_rvalid", if_rvalid, (cyc == resp_at) && resp_port == 1);
    chk("d_rvalid",  d_rvalid,  (cyc == resp_at) && resp_port == 0);
    chk("if_err", if_err, (cyc == resp_at) && resp_port == 1 && resp_err);
    chk("d_err",  d_err,  (cyc == resp_at) && resp_port == 0 && resp_err);
    chk("rdata", rdata, last_rdata);

    m_gi = 0; m_gd = 0;
    if (cyc >= m_free && (ir || dr)) begin
      win = (ir && dr) ? m_prio : (ir ? 1 : 0);
      if (win == 1) m_gi = 1; else m_gd = 1;
      a         = longint'(win == 1 ? ia : da);
      oob       = a > LIMIT;
      resp_data = oob ? 32'h0 : ref_word(a);
      resp_err  = oob;
      resp_port = win;
      resp_at   = cyc + 2;
      acc_at    = cyc + 1;
      acc_addr  = 32'(a);
      acc_we    = (win == 0) && dwe && !oob;
      acc_wd    = dwd;
      m_prio    = 1 - win;
      m_free    = cyc + 2;
    end
    chk("if_gnt", if_gnt, m_gi);
    chk("d_gnt",  d_gnt,  m_gd);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  logic [31:0] old;
  bit          ip, dp, dwe_r;
  logic [31:0] ia_r, da_r, dwd_r;
  string       gseq;

  initial begin
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'($urandom);
    ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h33; ref_mem[19] = 8'h44;

    // Reset held with both ports requesting; memory is loaded meanwhile.
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h4; d_addr = 32'h8; d_wdata = '0;
    @(posedge clk); #1;
    for (int i = 0; i < MB; i++) begin
      ld_en = 1'b1; ld_a = i; ld_d = ref_mem[i];
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
    chk("rst_if_gnt", if_gnt, 0);    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_if_err", if_err, 0);    chk("rst_d_err", d_err, 0);
    chk("rst_rdata", rdata, 0);      chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wd", mem_wd, 0);
    rst_n = 1'b1;
    model_reset();
    tick(1, 32'h4, 1, 0, 32'h8, 0);
    chk("first_gnt_is_data", {s_if_gnt, s_d_gnt}, 2'b01);
    idle(3);

    // Lone fetch at 0x10
    tick(1, 32'h10, 0, 0, 0, 0);
    chk("lone_if_gnt", s_if_gnt, 1);
    tick(0, 0, 0, 0, 0, 0);
    chk("lone_mem_addr", s_mem_addr, 32'h10);
    tick(0, 0, 0, 0, 0, 0);
    chk("lone_if_rvalid", s_if_rv, 1); chk("lone_if_err", s_if_err, 0);
    chk("lone_rdata", s_rdata, 32'h44332211); chk("lone_d_rvalid", s_d_rv, 0);
    idle(1);

    // Both requesting continuously: grants alternate starting with data
    gseq = "";
    for (int i = 0; i < 8; i++) begin
      tick(1, 32'(4 * i), 1, 0, 32'(8 + 4 * i), 0);
      if (s_d_gnt)  gseq = {gseq, "d"};
      if (s_if_gnt) gseq = {gseq, "i"};
    end
    n_cmp++;
    assert (gseq == "didi") else begin
      n_err++; $error("FAIL alt_grants: got %s expected didi", gseq);
    end
    idle(2);

    // Store then load at 0x20
    old = ref_word(32);
    tick(0, 0, 1, 1, 32'h20, 32'hDEADBEEF);
    tick(0, 0, 0, 0, 0, 0);
    chk("store_we", s_mem_we, 1);
    tick(0, 0, 0, 0, 0, 0);
    chk("store_old_data", s_rdata, old);
    tick(0, 0, 1, 0, 32'h20, 0);
    idle(2);
    chk("load_new_data", s_rdata, 32'hDEADBEEF);

    // Range boundary
    tick(0, 0, 1, 1, 32'd81, 32'hCAFEF00D);
    idle(2);
    chk("oob81_err", {s_d_rv, s_d_err}, 2'b11); chk("oob81_rdata", s_rdata, 0);
    tick(0, 0, 1, 0, 32'd80, 0);
    idle(2);
    chk("edge80_err", {s_d_rv, s_d_err}, 2'b10);
    chk("edge80_rdata", s_rdata, {ref_mem[83], ref_mem[82], ref_mem[81], ref_mem[80]});
    tick(1, 32'hFFFFFFFE, 0, 0, 0, 0);
    idle(2);
    chk("wrap_err", {s_if_rv, s_if_err}, 2'b11);

    // Reset pulsed during the access cycle of a store
    tick(0, 0, 1, 1, 32'h40, 32'h12345678);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    chk("midrst_we_before", mem_we, 1);
    rst_n = 1'b0; #1;
    chk("midrst_we_async", mem_we, 0);
    chk("midrst_gnt", {if_gnt, d_gnt}, 2'b00);
    @(posedge clk); #1;
    chk("midrst_no_rvalid", {if_rvalid, d_rvalid}, 2'b00);
    rst_n = 1'b1;
    cyc++;
    model_reset();
    idle(2);
    tick(1, 32'h0, 1, 0, 32'h40, 0);
    chk("midrst_prio_data", {s_if_gnt, s_d_gnt}, 2'b01);
    idle(2);
    chk("midrst_mem_kept", s_rdata, ref_word(64));

    // Randomized traffic; each port holds its request until granted
    ip = 0; dp = 0;
    for (int i = 0; i < 600; i++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1;
        ia_r = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 86));
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; dwe_r = 1'($urandom); dwd_r = $urandom;
        da_r = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 86));
      end
      tick(ip, ia_r, dp, dwe_r, da_r, dwd_r);
      if (m_gi) ip = 0;
      if (m_gd) dp = 0;
    end
    idle(3);

    for (int i = 0; i < MB; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    chk("no_oob_write", bad_wr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
